audio_channel: RTL and testbench
================================

// Module: audio_channel
// PURPOSE
//  One stereo playback voice of the 4-channel audio controller. After a CPU setup
//  (address, word count) it bus-masters 32-bit words from memory into a prefetch FIFO.
//  It plays one word per sample tick as a signed 16-bit left/right pair.
//  The parent arbitrates DMA between channels and mixes all channel outputs.
// PARAMETERS
//  FIFO_DEPTH   16   prefetch words; power of two, >=4
// PORTS
//  i_clock                in   1   system clock; everything on posedge
//  i_reset                in   1   synchronous, active-high reset
//  i_dma_setup_request    in   1   1-cycle strobe: start playback with address/count below
//  i_dma_setup_count      in   32  number of 32-bit sample words to play
//  i_dma_setup_address    in   32  byte address of first word (word aligned)
//  o_dma_request          out  1   DMA read request, held until i_dma_ready
//  o_dma_address          out  32  byte address of requested word, stable while requesting
//  i_dma_ready            in   1   1-cycle completion; i_dma_rdata valid this cycle
//  i_dma_rdata            in   32  read word: [15:0] left, [31:16] right (signed)
//  o_busy                 out  1   playback in progress
//  i_output_sample_clock  in   1   sample-rate tick, level signal in i_clock domain
//  o_output_sample_left   out  16  current left sample, signed
//  o_output_sample_right  out  16  current right sample, signed
// BEHAVIOUR
//  Reset: o_dma_request=0, o_dma_address=0, o_busy=0, samples=0, FIFO empty, remaining=0.
//  Setup strobe:
//  - latches addr and remaining=count; flushes FIFO; o_busy=1 next cycle if count!=0.
//  - count==0: channel goes idle; busy=0, FIFO flushed, samples keep their value.
//  Fetch FSM:
//  - IDLE->REQ when remaining!=0 and FIFO free slots>0.
//  - REQ: o_dma_request=1, o_dma_address=addr; hold both until i_dma_ready.
//  - On ready: push rdata, addr+=4 (wraps at 2^32), remaining-=1, ->GAP.
//  - GAP: request=0 for exactly one cycle, then ->IDLE. Never assert request two cycles after ready.
//  - Ready while not in REQ is ignored.
//  - Setup while in REQ: request stays high until ready; that word is discarded,
//    addr/remaining are not advanced, and the new setup values apply.
//  Playback:
//  - Tick = rising edge of i_output_sample_clock (prev low, now high; prev reg resets to 0).
//  - On tick, FIFO non-empty: pop; left/right update the cycle after the edge cycle.
//  - On tick, FIFO empty: outputs forced to 0 (silence, no stale sum in the mixer).
//  - Outputs hold between ticks.
//  - Tick and DMA push in the same cycle with the FIFO empty: the pushed word is not
//    visible until the next tick; outputs go 0.
//  - Simultaneous push+pop on a full FIFO never happens, because fetch needs free slots.
//  o_busy=1 while remaining!=0 or FIFO non-empty or REQ outstanding. It falls on the cycle
//  after the last word is popped. During that word's playback period it is already 0.
//  Reset mid-transfer: request dropped immediately; the parent must drop ready.
// STRUCTURE
//  Package audio_pkg:
//  - typedef stereo_sample_t {logic signed [15:0] right, left;}, packed so that
//    [31:16]=right, [15:0]=left.
//  - constants SAMPLE_W=16, WORD_BYTES=4, FIFO_DEPTH_DEFAULT=16.
//  Sub-module audio_sample_fifo:
//  - sync FIFO with push/pop/flush/empty/free_count, registered read.
//  Top:
//  - fetch FSM, address/remaining counters, tick edge detect, output regs.
// TESTING
//  - Reset: all outputs 0, o_busy=0 after one clock with i_reset=1.
//  - Setup addr=0x1000, count=3, memory model ready 2 cycles after request:
//    - requests at 0x1000/0x1004/0x1008, each followed by one low gap cycle;
//    - busy=1 next cycle.
//  - Words 0x7FFF8000, 0x00010002, 0xFFFF0000 then 4 ticks:
//    - outputs (L,R)=(0x8000,0x7FFF), (0x0002,0x0001), (0x0000,0xFFFF), then (0,0);
//    - busy falls after the third pop.
//  - Count=40 with ticks withheld: exactly FIFO_DEPTH words fetched, then request stays
//    low; each tick then triggers a refill fetch.
//  - Setup count=5 issued while a request is pending: pending word discarded; next output
//    comes from the new address; count=0 setup clears busy.
//  - i_output_sample_clock held high 10 cycles: exactly one pop; addr 0xFFFFFFFC count=2
//    wraps to 0x00000000.

Source files
------------

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the stereo playback channel
package audio_pkg;
  localparam int SAMPLE_W           = 16;
  localparam int WORD_BYTES         = 4;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  // Packed so a memory word maps directly: [31:16] right, [15:0] left.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] right;
    logic signed [SAMPLE_W-1:0] left;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_GAP  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - prefetch FIFO with flush, free count and registered read port
module audio_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_free_count
);
  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_ONE   = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_count      = r_wr_ptr - r_rd_ptr;
  assign w_full       = (w_count == L_DEPTH);
  assign o_empty      = (w_count == '0);
  assign o_free_count = L_DEPTH - w_count;
  assign o_rdata      = r_rdata;
  assign w_do_push    = i_push & ~w_full & ~i_flush;
  assign w_do_pop     = i_pop & ~o_empty & ~i_flush;

  // Flush keeps r_rdata so the channel outputs hold their last value.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_rdata  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + L_ONE;
      if (w_do_pop) begin
        r_rdata  <= r_mem[r_rd_ptr[AW-1:0]];
        r_rd_ptr <= r_rd_ptr + L_ONE;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end
endmodule

// File: rtl/audio_channel.sv
// rtl/audio_channel.sv - one stereo playback voice: DMA prefetch into a FIFO, one word per sample tick
module audio_channel
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_dma_setup_request,
  input  logic [31:0] i_dma_setup_count,
  input  logic [31:0] i_dma_setup_address,
  output logic        o_dma_request,
  output logic [31:0] o_dma_address,
  input  logic        i_dma_ready,
  input  logic [31:0] i_dma_rdata,
  output logic        o_busy,
  input  logic        i_output_sample_clock,
  output logic [15:0] o_output_sample_left,
  output logic [15:0] o_output_sample_right
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   r_state;
  logic [31:0]    r_addr;
  logic [31:0]    r_remaining;
  logic [31:0]    r_req_addr;
  logic           r_dma_request;
  logic           r_discard;
  logic           r_sample_prev;
  logic           r_tick_d;
  logic           r_tick_data;
  stereo_sample_t r_sample;

  logic           w_tick;
  logic           w_ready_req;
  logic           w_push;
  logic           w_pop;
  logic           w_fifo_empty;
  logic [CW-1:0]  w_free;
  logic [31:0]    w_fifo_rdata;

  assign w_tick      = i_output_sample_clock & ~r_sample_prev;
  assign w_ready_req = (r_state == FETCH_REQ) & i_dma_ready;
  // A word whose request straddled a new setup belongs to the old stream.
  assign w_push      = w_ready_req & ~r_discard & ~i_dma_setup_request;
  assign w_pop       = w_tick & ~w_fifo_empty & ~i_dma_setup_request;

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_flush      (i_dma_setup_request),
    .i_push       (w_push),
    .i_wdata      (i_dma_rdata),
    .i_pop        (w_pop),
    .o_rdata      (w_fifo_rdata),
    .o_empty      (w_fifo_empty),
    .o_free_count (w_free)
  );

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= FETCH_IDLE;
      r_dma_request <= 1'b0;
      r_req_addr    <= '0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_discard     <= 1'b0;
    end else begin
      case (r_state)
        FETCH_IDLE: begin
          if (!i_dma_setup_request && r_remaining != '0 && w_free != '0) begin
            r_state       <= FETCH_REQ;
            r_dma_request <= 1'b1;
            r_req_addr    <= r_addr;
          end
        end
        FETCH_REQ: begin
          if (i_dma_ready) begin
            r_state       <= FETCH_GAP;
            r_dma_request <= 1'b0;
            r_discard     <= 1'b0;
            if (w_push) begin
              r_addr      <= r_addr + 32'(WORD_BYTES);
              r_remaining <= r_remaining - 32'd1;
            end
          end else if (i_dma_setup_request) begin
            r_discard <= 1'b1;
          end
        end
        FETCH_GAP: r_state <= FETCH_IDLE;
        default: begin
          r_state       <= FETCH_IDLE;
          r_dma_request <= 1'b0;
        end
      endcase
      if (i_dma_setup_request) begin
        r_addr      <= i_dma_setup_address;
        r_remaining <= i_dma_setup_count;
      end
    end
  end

  // An empty tick outputs silence so the mixer never sums a stale sample.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sample_prev <= 1'b0;
      r_tick_d      <= 1'b0;
      r_tick_data   <= 1'b0;
      r_sample      <= '0;
    end else begin
      r_sample_prev <= i_output_sample_clock;
      r_tick_d      <= w_tick;
      r_tick_data   <= w_pop;
      if (r_tick_d) r_sample <= r_tick_data ? stereo_sample_t'(w_fifo_rdata) : '0;
    end
  end

  assign o_dma_request         = r_dma_request;
  assign o_dma_address         = r_req_addr;
  assign o_busy                = (r_remaining != '0) | ~w_fifo_empty | (r_state == FETCH_REQ);
  assign o_output_sample_left  = r_sample.left;
  assign o_output_sample_right = r_sample.right;
endmodule

// File: tb/tb_audio_channel.sv
// tb/tb_audio_channel.sv - randomized self-checking bench for audio_channel against a queue-based model
module tb_audio_channel;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_dma_setup_request;
  logic [31:0] i_dma_setup_count;
  logic [31:0] i_dma_setup_address;
  logic        o_dma_request;
  logic [31:0] o_dma_address;
  logic        i_dma_ready;
  logic [31:0] i_dma_rdata;
  logic        o_busy;
  logic        i_output_sample_clock;
  logic [15:0] o_output_sample_left;
  logic [15:0] o_output_sample_right;

  audio_channel #(.FIFO_DEPTH(DEPTH)) dut (
    .i_clock               (clk),
    .i_reset               (i_reset),
    .i_dma_setup_request   (i_dma_setup_request),
    .i_dma_setup_count     (i_dma_setup_count),
    .i_dma_setup_address   (i_dma_setup_address),
    .o_dma_request         (o_dma_request),
    .o_dma_address         (o_dma_address),
    .i_dma_ready           (i_dma_ready),
    .i_dma_rdata           (i_dma_rdata),
    .o_busy                (o_busy),
    .i_output_sample_clock (i_output_sample_clock),
    .o_output_sample_left  (o_output_sample_left),
    .o_output_sample_right (o_output_sample_right)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_checks = 0;
  int lat_cnt = 0, resp_lat = 0, gap_cnt = 0, stall = 0, n_fetched = 0;
  logic rst_go = 0, rst_prev = 0, setup_go = 0, tick_lvl = 0, prev_req = 0;
  logic m_prev_lvl = 0, m_discard = 0, m_apply = 0;
  logic [31:0] setup_a = 0, setup_c = 0, cap_addr = 0;
  logic [31:0] m_addr = 0, m_rem = 0, m_out = 0, m_apply_val = 0;
  logic [31:0] m_fifo[$];
  logic [31:0] req_log[$];
  logic [31:0] mem_over[logic [31:0]];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_over.exists(a)) return mem_over[a];
    return {a[17:2] ^ 16'h5A3C, ~a[15:0] + a[31:16]};
  endfunction

  task automatic observe();
    logic exp_busy;
    if (rst_prev) check_eq("req_after_reset", o_dma_request, 0);
    check_eq("left", o_output_sample_left, m_out[15:0]);
    check_eq("right", o_output_sample_right, m_out[31:16]);
    exp_busy = (m_rem != 0) || (m_fifo.size() != 0) || o_dma_request;
    check_eq("busy", o_busy, exp_busy);
    if (gap_cnt > 0) begin
      check_eq("gap", o_dma_request, 0);
      gap_cnt--;
    end
    if (o_dma_request && !prev_req) begin
      check_eq("req_addr", o_dma_address, m_addr);
      check_eq("req_allowed", (m_rem != 0 && m_fifo.size() < DEPTH), 1);
      cap_addr = o_dma_address;
      req_log.push_back(o_dma_address);
    end else if (o_dma_request) begin
      check_eq("addr_stable", o_dma_address, cap_addr);
    end
    if (!o_dma_request && m_rem != 0 && m_fifo.size() < DEPTH) stall++;
    else stall = 0;
    check_eq("stall", stall > 3, 0);
    prev_req = o_dma_request;
  endtask

  // Reference behaviour for the coming clock edge, from the inputs just chosen.
  task automatic model_update();
    logic tick;
    if (i_reset) begin
      m_fifo.delete();
      m_addr = 0; m_rem = 0; m_out = 0; m_apply = 0;
      m_prev_lvl = 0; m_discard = 0; gap_cnt = 0;
      return;
    end
    if (m_apply) begin
      m_out = m_apply_val;
      m_apply = 0;
    end
    tick = i_output_sample_clock && !m_prev_lvl;
    m_prev_lvl = i_output_sample_clock;
    if (tick) begin
      m_apply = 1;
      if (!i_dma_setup_request && m_fifo.size() != 0) m_apply_val = m_fifo.pop_front();
      else m_apply_val = 32'd0;
    end
    if (i_dma_ready) begin
      if (!m_discard && !i_dma_setup_request) begin
        m_fifo.push_back(mem_word(m_addr));
        m_addr = m_addr + 32'd4;
        m_rem = m_rem - 32'd1;
        n_fetched++;
      end
      m_discard = 0;
    end
    if (i_dma_setup_request) begin
      m_fifo.delete();
      m_addr = i_dma_setup_address;
      m_rem = i_dma_setup_count;
      m_discard = o_dma_request && !i_dma_ready;
    end
  endtask

  task automatic cycle();
    observe();
    i_reset = rst_go;
    i_dma_ready = 1'b0;
    if (!rst_go && o_dma_request) begin
      if (lat_cnt >= resp_lat) begin
        i_dma_ready = 1'b1;
        i_dma_rdata = mem_word(o_dma_address);
        lat_cnt = 0;
        gap_cnt = 2;
      end else lat_cnt++;
    end else lat_cnt = 0;
    i_dma_setup_request = setup_go;
    i_dma_setup_address = setup_a;
    i_dma_setup_count = setup_c;
    i_output_sample_clock = tick_lvl;
    model_update();
    rst_prev = rst_go;
    setup_go = 0;
    rst_go = 0;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic tick_once();
    tick_lvl = 1; cycle(); cycle();
    tick_lvl = 0; cycle(); cycle();
  endtask

  task automatic setup(input logic [31:0] a, input logic [31:0] c);
    setup_go = 1; setup_a = a; setup_c = c;
    n_fetched = 0;
    cycle();
  endtask

  task automatic check_out(input string tag, input logic [31:0] w);
    check_eq({tag, "_L"}, o_output_sample_left, w[15:0]);
    check_eq({tag, "_R"}, o_output_sample_right, w[31:16]);
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1; i_dma_setup_request = 0; i_dma_setup_count = 0; i_dma_setup_address = 0;
    i_dma_ready = 0; i_dma_rdata = 0; i_output_sample_clock = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_req", o_dma_request, 0);
    check_eq("rst_addr", o_dma_address, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_left", o_output_sample_left, 0);
    check_eq("rst_right", o_output_sample_right, 0);
    i_reset = 0;

    // Three known words at 0x1000, two-cycle memory latency.
    mem_over[32'h1000] = 32'h7FFF8000;
    mem_over[32'h1004] = 32'h00010002;
    mem_over[32'h1008] = 32'hFFFF0000;
    resp_lat = 2;
    req_log.delete();
    setup(32'h1000, 3);
    check_eq("t1_busy_next", o_busy, 1);
    run(30);
    check_eq("t1_nreq", req_log.size(), 3);
    if (req_log.size() == 3) begin
      check_eq("t1_req0", req_log[0], 32'h1000);
      check_eq("t1_req1", req_log[1], 32'h1004);
      check_eq("t1_req2", req_log[2], 32'h1008);
    end
    tick_once(); check_out("t1_s0", 32'h7FFF8000);
    tick_once(); check_out("t1_s1", 32'h00010002);
    check_eq("t1_busy_2", o_busy, 1);
    tick_once(); check_out("t1_s2", 32'hFFFF0000);
    check_eq("t1_busy_3", o_busy, 0);
    tick_once(); check_out("t1_s3", 32'h0);

    // Long stream with ticks withheld: fill exactly to depth, then refill per tick.
    resp_lat = $urandom_range(0, 3);
    setup(32'h2000, 40);
    run(160);
    check_eq("t2_fill", n_fetched, DEPTH);
    check_eq("t2_req_low", o_dma_request, 0);
    tick_once(); run(10);
    check_out("t2_first", mem_word(32'h2000));
    check_eq("t2_refill1", n_fetched, DEPTH + 1);
    tick_once(); run(10);
    check_eq("t2_refill2", n_fetched, DEPTH + 2);

    // New setup while a request is outstanding.
    resp_lat = 5;
    tick_once();
    for (int k = 0; k < 20 && !o_dma_request; k++) cycle();
    check_eq("t3_req_seen", o_dma_request, 1);
    setup(32'h3000, 5);
    resp_lat = 1;
    run(60);
    check_eq("t3_fetched", n_fetched, 5);
    tick_once();
    check_out("t3_first", mem_word(32'h3000));
    setup(32'h4000, 0);
    check_eq("t3_idle_busy", o_busy, 0);
    run(5);
    check_out("t3_hold", mem_word(32'h3000));

    // Level held high yields one pop; address wraps past 2^32.
    req_log.delete();
    setup(32'hFFFFFFFC, 2);
    run(30);
    check_eq("t4_nreq", req_log.size(), 2);
    if (req_log.size() == 2) begin
      check_eq("t4_req0", req_log[0], 32'hFFFFFFFC);
      check_eq("t4_req1", req_log[1], 32'h00000000);
    end
    tick_lvl = 1; run(10);
    tick_lvl = 0; run(2);
    check_out("t4_one_pop", mem_word(32'hFFFFFFFC));
    check_eq("t4_busy", o_busy, 1);
    tick_once();
    check_out("t4_wrap", mem_word(32'h0));
    check_eq("t4_done", o_busy, 0);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500 || $urandom_range(0, 999) == 0) rst_go = 1;
      if ($urandom_range(0, 119) == 0) begin
        setup_go = 1;
        setup_c = $urandom_range(0, 24);
        if ($urandom_range(0, 3) == 0) setup_a = 32'hFFFFFFF0 + 32'($urandom_range(0, 3)) * 4;
        else setup_a = $urandom() & 32'hFFFF_FFFC;
        resp_lat = $urandom_range(0, 3);
      end
      if ($urandom_range(0, 3) == 0) tick_lvl = ~tick_lvl;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
